poly_horner_seq: RTL and testbench
==================================

POLY_HORNER_SEQ -- requirements
Module: poly_horner_seq

Interface
REQ-001 Parameter DATA_W, default 16: width of input sample x and of each coefficient, unsigned.
REQ-002 Parameter DEGREE, default 3: polynomial degree; legal range 1..15.
REQ-003 Parameter OUT_W, default 48: result width; legal range OUT_W >= DATA_W.
REQ-004 in_clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 in_reset_n  input  1  asynchronous, active-low reset.
REQ-006 axis_s_tvalid  input  1  input sample valid.
REQ-007 axis_s_tready  output  1  block can accept a sample.
REQ-008 axis_s_tdata  input  DATA_W  sample x.
REQ-009 in_coef  input  (DEGREE+1)*DATA_W  coefficients; c[i] at bits [i*DATA_W +: DATA_W], c[0] is the constant term.
REQ-010 axis_m_tvalid  output  1  result valid.
REQ-011 axis_m_tready  input  1  downstream accepts the result.
REQ-012 axis_m_tdata  output  OUT_W  p(x) = sum c[i]*x^i.

Function
REQ-013 FSM states: IDLE, CALC, OUT; encoding free.
REQ-014 axis_s_tready SHALL be 1 only in IDLE; axis_m_tvalid SHALL be 1 only in OUT.
REQ-015 IDLE with axis_s_tvalid=1: latch x and all of in_coef; acc <= zero-extended c[DEGREE]; idx <= DEGREE-1; go to CALC.
REQ-016 CALC, each cycle: acc <= acc*x + c[idx] (Horner); if idx==0 go to OUT, else idx <= idx-1.
REQ-017 Exactly one multiply-add per cycle; axis_m_tvalid rises DEGREE clock edges after the accepting edge.
REQ-018 Arithmetic is unsigned; each step is computed at full width, then reduced to OUT_W per REQ-027/REQ-028.
REQ-019 In OUT, axis_m_tdata SHALL equal acc and stay stable while axis_m_tready=0.
REQ-020 axis_m_tvalid SHALL NOT depend combinationally on axis_m_tready.
REQ-021 OUT with axis_m_tready=1: go to IDLE; the next sample is accepted no earlier than the following edge.
REQ-022 in_coef and axis_s_tdata changes after acceptance SHALL NOT affect the in-flight result.
REQ-023 axis_m_tready is ignored outside OUT; axis_s_tvalid is ignored outside IDLE.

Reset
REQ-024 in_reset_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, acc=0, idx=0, x=0, latched coefficients=0, axis_m_tvalid=0, axis_s_tready=1, axis_m_tdata=0.
REQ-025 Reset asserted in CALC or OUT discards the in-flight result; no partial result is ever presented.
REQ-026 The first acceptance is possible on the first rising edge after in_reset_n deasserts.

Configuration
REQ-027 Without macro POLY_HORNER_SAT_EN: each step keeps the low OUT_W bits (modulo 2^OUT_W).
REQ-028 With POLY_HORNER_SAT_EN defined: a sticky overflow flag sets when any step's full-width value exceeds 2^OUT_W-1; in OUT, axis_m_tdata SHALL be all-ones if the flag is set. The flag clears on acceptance and on reset. The port list is identical in both builds.

Verification
REQ-029 Defaults, c={c3=1,c2=2,c1=1,c0=1}, x=3 -> axis_m_tvalid 3 edges after acceptance, axis_m_tdata=49 (0x31).
REQ-030 Same setup, axis_m_tready held 0 for 10 cycles -> tvalid stays 1, tdata stays 49, axis_s_tready stays 0; result released on the first cycle with tready=1.
REQ-031 OUT_W=16, c={1,0,0,0}, x=0x0100 -> without SAT_EN tdata=0x0000; with SAT_EN tdata=0xFFFF.
REQ-032 Reset pulsed low in the second CALC cycle -> tvalid=0 and s_tready=1 at once; a new sample x=2 then gives 1+2*4... full value p(2)=8+8+2+1=19, with no trace of the aborted run.
REQ-033 DEGREE=1, c1=5, c0=7, x=4 -> tvalid one edge after acceptance, tdata=27.
REQ-034 in_coef and axis_s_tdata changed to random values every cycle during CALC -> result still matches the values latched at acceptance.

Source files
------------

// File: rtl/poly_horner_seq_if.sv
// -----------------------------------------------------------------------------
// poly_horner_seq_if
// Bundles the sample stream, coefficient bus and result stream of
// poly_horner_seq. The clock and reset are not part of this bundle.
//
// Handshake: a transfer happens on a rising edge where tvalid and tready are
// both 1. The producer holds tvalid and its data stable until that edge, and
// tvalid never depends combinationally on tready.
//
// Signals
//   axis_s_tvalid  upstream -> block   sample x is valid
//   axis_s_tready  block -> upstream   block can accept a sample
//   axis_s_tdata   upstream -> block   sample x, DATA_W bits, unsigned
//   in_coef        upstream -> block   c[i] at [i*DATA_W +: DATA_W]
//   axis_m_tvalid  block -> downstream result valid
//   axis_m_tready  downstream -> block result accepted
//   axis_m_tdata   block -> downstream p(x), OUT_W bits
//   dbg_state      block -> observer   current FSM state (debug only)
//
// Modports
//   slave  : the polynomial block itself
//   master : the environment that feeds samples and drains results
// -----------------------------------------------------------------------------
interface poly_horner_seq_if #(
   parameter int DATA_W = 16,
   parameter int DEGREE = 3,
   parameter int OUT_W  = 48
);
   logic                         axis_s_tvalid;
   logic                         axis_s_tready;
   logic [DATA_W-1:0]            axis_s_tdata;
   logic [(DEGREE+1)*DATA_W-1:0] in_coef;
   logic                         axis_m_tvalid;
   logic                         axis_m_tready;
   logic [OUT_W-1:0]             axis_m_tdata;
   logic [1:0]                   dbg_state;

   modport slave (
      input  axis_s_tvalid, axis_s_tdata, in_coef, axis_m_tready,
      output axis_s_tready, axis_m_tvalid, axis_m_tdata, dbg_state
   );

   modport master (
      output axis_s_tvalid, axis_s_tdata, in_coef, axis_m_tready,
      input  axis_s_tready, axis_m_tvalid, axis_m_tdata, dbg_state
   );
endinterface

// File: rtl/poly_horner_seq.sv
// -----------------------------------------------------------------------------
// poly_horner_seq
// Sequential polynomial evaluator: p(x) = sum c[i]*x^i, unsigned, computed by
// Horner's rule with one multiply-add per clock.
//
// Ports
//   in_clock    sole clock, rising edge
//   in_reset_n  asynchronous active-low reset
//   bus         poly_horner_seq_if.slave (sample in, coefficients, result out)
//
// Flow: IDLE accepts a sample and snapshots x and all coefficients, CALC runs
// DEGREE Horner steps, OUT holds the result until the downstream takes it.
//
// Build option POLY_HORNER_SAT_EN: when defined, any step whose full-width
// value does not fit OUT_W bits sets a sticky overflow flag and the result is
// presented as all-ones. When undefined, every step wraps modulo 2^OUT_W.
// The port list is the same in both builds.
// -----------------------------------------------------------------------------
module poly_horner_seq #(
   parameter int DATA_W = 16,
   parameter int DEGREE = 3,
   parameter int OUT_W  = 48
) (
   input  logic              in_clock,
   input  logic              in_reset_n,
   poly_horner_seq_if.slave  bus
);

   localparam int COEF_W = (DEGREE + 1) * DATA_W;
   localparam int IDX_W  = (DEGREE < 2) ? 1 : $clog2(DEGREE + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   x_q, x_d;
   logic [COEF_W-1:0]   coef_q, coef_d;
   logic [OUT_W-1:0]    acc_q, acc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;

   logic                accept;
   logic                last_step;
   logic [DATA_W-1:0]   coef_sel;
   logic [OUT_W-1:0]    step_res;

   assign accept    = (state_q == ST_IDLE) && bus.axis_s_tvalid;
   assign last_step = (idx_q == '0);

   // Coefficient c[idx] from the snapshot taken at acceptance, so input bus
   // changes during CALC cannot leak into the running evaluation.
   always_comb begin
      coef_sel = '0;
      for (int i = 0; i <= DEGREE; i++) begin
         if (idx_q == IDX_W'(i)) begin
            coef_sel = coef_q[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef POLY_HORNER_SAT_EN
   // The full product-plus-addend needs OUT_W+DATA_W+1 bits; anything above
   // bit OUT_W-1 means this step did not fit.
   localparam int FULL_W = OUT_W + DATA_W + 1;

   logic [FULL_W-1:0] step_full;
   logic              step_ovf;
   logic              ovf_q, ovf_d;

   always_comb begin
      step_full = FULL_W'(acc_q) * FULL_W'(x_q) + FULL_W'(coef_sel);
      step_res  = step_full[OUT_W-1:0];
      step_ovf  = |step_full[FULL_W-1:OUT_W];
   end

   // Sticky across the whole evaluation; a new acceptance starts clean.
   always_comb begin
      ovf_d = ovf_q;
      if (accept) begin
         ovf_d = 1'b0;
      end else if ((state_q == ST_CALC) && step_ovf) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end
`else
   // Only the low OUT_W bits are kept, so the step is computed directly at
   // OUT_W width; the truncation is the intended modulo behaviour.
   always_comb begin
      step_res = acc_q * OUT_W'(x_q) + OUT_W'(coef_sel);
   end
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.axis_s_tvalid) state_d = ST_CALC;
         ST_CALC: if (last_step)         state_d = ST_OUT;
         ST_OUT:  if (bus.axis_m_tready) state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // The result bus is forced to zero outside OUT so intermediate Horner
   // values are never visible on it.
   always_comb begin
      bus.axis_s_tready = (state_q == ST_IDLE);
      bus.axis_m_tvalid = (state_q == ST_OUT);
      bus.axis_m_tdata  = '0;
      bus.dbg_state     = state_q;
      if (state_q == ST_OUT) begin
         bus.axis_m_tdata = acc_q;
`ifdef POLY_HORNER_SAT_EN
         if (ovf_q) begin
            bus.axis_m_tdata = '1;
         end
`endif
      end
   end

   // ---------------- Datapath ----------------
   always_comb begin
      x_d    = x_q;
      coef_d = coef_q;
      acc_d  = acc_q;
      idx_d  = idx_q;
      if (accept) begin
         x_d    = bus.axis_s_tdata;
         coef_d = bus.in_coef;
         acc_d  = OUT_W'(bus.in_coef[DEGREE*DATA_W +: DATA_W]);
         idx_d  = IDX_W'(DEGREE - 1);
      end else if (state_q == ST_CALC) begin
         acc_d = step_res;
         if (!last_step) begin
            idx_d = idx_q - 1'b1;
         end
      end
   end

   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         x_q    <= '0;
         coef_q <= '0;
         acc_q  <= '0;
         idx_q  <= '0;
      end else begin
         x_q    <= x_d;
         coef_q <= coef_d;
         acc_q  <= acc_d;
         idx_q  <= idx_d;
      end
   end

endmodule

// File: tb/tb_poly_horner_seq.sv
// -----------------------------------------------------------------------------
// tb_poly_horner_seq
// Three instances: default (DEGREE=3, OUT_W=48), narrow result (OUT_W=16) and
// DEGREE=1. Expected results come from a direct sum-of-powers model, with
// saturation judged against the exact (unbounded) polynomial value.
// -----------------------------------------------------------------------------
module tb_poly_horner_seq;

`ifdef POLY_HORNER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- stimulus / observation ----------------
   logic        s_tvalid[3];
   logic        m_tready[3];
   logic [15:0] s_tdata;
   logic [63:0] coef;

   logic        m_tvalid_w[3];
   logic        s_tready_w[3];
   logic [47:0] m_tdata_w[3];
   logic [1:0]  dbg[3];
   logic [1:0]  idle_code[3];

   int deg_k[3]  = '{3, 3, 1};
   int outw_k[3] = '{48, 16, 48};

   int checks;
   int errors;

   poly_horner_seq_if #(.DATA_W(16), .DEGREE(3), .OUT_W(48)) if_d3  ();
   poly_horner_seq_if #(.DATA_W(16), .DEGREE(3), .OUT_W(16)) if_w16 ();
   poly_horner_seq_if #(.DATA_W(16), .DEGREE(1), .OUT_W(48)) if_d1  ();

   assign if_d3.axis_s_tvalid  = s_tvalid[0];
   assign if_d3.axis_s_tdata   = s_tdata;
   assign if_d3.in_coef        = coef;
   assign if_d3.axis_m_tready  = m_tready[0];
   assign m_tvalid_w[0]        = if_d3.axis_m_tvalid;
   assign s_tready_w[0]        = if_d3.axis_s_tready;
   assign m_tdata_w[0]         = if_d3.axis_m_tdata;
   assign dbg[0]               = if_d3.dbg_state;

   assign if_w16.axis_s_tvalid = s_tvalid[1];
   assign if_w16.axis_s_tdata  = s_tdata;
   assign if_w16.in_coef       = coef;
   assign if_w16.axis_m_tready = m_tready[1];
   assign m_tvalid_w[1]        = if_w16.axis_m_tvalid;
   assign s_tready_w[1]        = if_w16.axis_s_tready;
   assign m_tdata_w[1]         = 48'(if_w16.axis_m_tdata);
   assign dbg[1]               = if_w16.dbg_state;

   assign if_d1.axis_s_tvalid  = s_tvalid[2];
   assign if_d1.axis_s_tdata   = s_tdata;
   assign if_d1.in_coef        = coef[31:0];
   assign if_d1.axis_m_tready  = m_tready[2];
   assign m_tvalid_w[2]        = if_d1.axis_m_tvalid;
   assign s_tready_w[2]        = if_d1.axis_s_tready;
   assign m_tdata_w[2]         = if_d1.axis_m_tdata;
   assign dbg[2]               = if_d1.dbg_state;

   poly_horner_seq #(.DATA_W(16), .DEGREE(3), .OUT_W(48)) u_d3 (
      .in_clock(clk), .in_reset_n(rst_n), .bus(if_d3.slave));
   poly_horner_seq #(.DATA_W(16), .DEGREE(3), .OUT_W(16)) u_w16 (
      .in_clock(clk), .in_reset_n(rst_n), .bus(if_w16.slave));
   poly_horner_seq #(.DATA_W(16), .DEGREE(1), .OUT_W(48)) u_d1 (
      .in_clock(clk), .in_reset_n(rst_n), .bus(if_d1.slave));

   // ---------------- reference model ----------------
   function automatic logic [127:0] p_exact(input logic [63:0] c, input logic [15:0] x,
                                            input int deg);
      logic [127:0] s;
      logic [127:0] pw;
      s  = '0;
      pw = 128'd1;
      for (int i = 0; i <= deg; i++) begin
         s  = s + 128'(c[i*16 +: 16]) * pw;
         pw = pw * 128'(x);
      end
      return s;
   endfunction

   // Horner intermediates never exceed the final value when x >= 1 (and stay
   // single coefficients when x == 0), so overflow of any step is equivalent
   // to the exact value not fitting OUT_W bits.
   function automatic logic [47:0] model_p(input logic [63:0] c, input logic [15:0] x,
                                           input int k);
      logic [127:0] ex;
      logic [127:0] mask;
      ex   = p_exact(c, x, deg_k[k]);
      mask = (128'd1 << outw_k[k]) - 128'd1;
      if (SAT && (ex > mask)) return 48'(mask);
      return 48'(ex & mask);
   endfunction

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Drives one sample into instance k starting at a negedge, scrambles the
   // inputs every cycle while the result is in flight, holds m_tready low for
   // 'hold' cycles in OUT, then releases. Ends at a negedge with k in IDLE.
   task automatic run(input int k, input logic [63:0] c, input logic [15:0] x,
                      input logic [47:0] exp, input int hold, input string name);
      int lat;
      chk($sformatf("%s/s_tready_pre", name), 64'(s_tready_w[k]), 64'd1);
      s_tvalid[k] = 1'b1;
      s_tdata     = x;
      coef        = c;
      m_tready[k] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lat = 0;
      while (!m_tvalid_w[k] && lat < 40) begin
         s_tvalid[k] = 1'($urandom_range(0, 1));
         m_tready[k] = 1'($urandom_range(0, 1));
         s_tdata     = 16'($urandom);
         coef        = {$urandom, $urandom};
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      s_tvalid[k] = 1'b1;
      m_tready[k] = 1'b0;
      chk($sformatf("%s/latency", name), 64'(lat), 64'(deg_k[k]));
      chk($sformatf("%s/tdata", name), 64'(m_tdata_w[k]), 64'(exp));
      chk($sformatf("%s/s_tready_busy", name), 64'(s_tready_w[k]), 64'd0);
      chk($sformatf("%s/dbg_out", name), 64'(dbg[k] != idle_code[k]), 64'd1);
      repeat (hold) begin
         s_tdata = 16'($urandom);
         coef    = {$urandom, $urandom};
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("%s/hold_tvalid", name), 64'(m_tvalid_w[k]), 64'd1);
         chk($sformatf("%s/hold_tdata", name), 64'(m_tdata_w[k]), 64'(exp));
         chk($sformatf("%s/hold_s_tready", name), 64'(s_tready_w[k]), 64'd0);
      end
      m_tready[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      m_tready[k] = 1'b0;
      s_tvalid[k] = 1'b0;
      chk($sformatf("%s/tvalid_done", name), 64'(m_tvalid_w[k]), 64'd0);
      chk($sformatf("%s/s_tready_done", name), 64'(s_tready_w[k]), 64'd1);
      chk($sformatf("%s/dbg_idle", name), 64'(dbg[k]), 64'(idle_code[k]));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [63:0] c;
      logic [15:0] x;
      logic [47:0] exp;
      int          hold;
      string       name;
   } vec_t;

   vec_t vecs[8];

   // ---------------- main sequence ----------------
   initial begin
      logic [63:0] rc;
      logic [15:0] rx;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      s_tdata = '0;
      coef    = '0;
      for (int k = 0; k < 3; k++) begin
         s_tvalid[k] = 1'b0;
         m_tready[k] = 1'b0;
      end

      vecs[0] = '{{16'd1, 16'd2, 16'd1, 16'd1}, 16'd3, 48'd49, 0, "basic49"};
      vecs[1] = '{{16'd1, 16'd2, 16'd1, 16'd1}, 16'd3, 48'd49, 10, "stall49"};
      vecs[2] = '{64'd0, 16'd5, 48'd0, 1, "zero_coef"};
      vecs[3] = '{{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1234}, 16'd0, 48'h1234, 0, "x_zero"};
      vecs[4] = '{{16'd1, 16'd2, 16'd3, 16'd4}, 16'd1, 48'd10, 2, "x_one"};
      vecs[5] = '{{16'd1, 16'd0, 16'd0, 16'd0}, 16'd2, 48'd8, 0, "cube2"};
      vecs[6] = '{{16'h0010, 16'd0, 16'd0, 16'd0}, 16'h0010, 48'h10000, 3, "cube16"};
      vecs[7] = '{{16'd0, 16'd0, 16'hFFFF, 16'hFFFF}, 16'hFFFF, 48'hFFFF0000, 0, "lin_max"};

      // Reset values, observed before any clock edge.
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset%0d/s_tready", k), 64'(s_tready_w[k]), 64'd1);
         chk($sformatf("reset%0d/tvalid", k), 64'(m_tvalid_w[k]), 64'd0);
         chk($sformatf("reset%0d/tdata", k), 64'(m_tdata_w[k]), 64'd0);
         idle_code[k] = dbg[k];
      end

      // Acceptance on the very first edge after reset release.
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run(0, vecs[i].c, vecs[i].x, vecs[i].exp, vecs[i].hold, vecs[i].name);
      end

      // Narrow result: x^3 overflows 16 bits, then a clean run must not
      // inherit the overflow.
      run(1, {16'd1, 16'd0, 16'd0, 16'd0}, 16'h0100, SAT ? 48'hFFFF : 48'h0, 0, "w16_ovf");
      run(1, {16'd0, 16'd0, 16'd1, 16'd2}, 16'd3, 48'd5, 0, "w16_clean");

      // Degree one.
      run(2, {32'd0, 16'd5, 16'd7}, 16'd4, 48'd27, 1, "deg1");

      // Reset during the second CALC cycle.
      s_tvalid[0] = 1'b1;
      s_tdata     = 16'd3;
      coef        = {16'd1, 16'd2, 16'd1, 16'd1};
      @(posedge clk);
      @(negedge clk);
      s_tvalid[0] = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort/tvalid", 64'(m_tvalid_w[0]), 64'd0);
      chk("abort/s_tready", 64'(s_tready_w[0]), 64'd1);
      chk("abort/tdata", 64'(m_tdata_w[0]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run(0, {16'd1, 16'd2, 16'd1, 16'd1}, 16'd2, 48'd19, 0, "after_abort");

      // Randomized runs on all three instances.
      for (int i = 0; i < 45; i++) begin
         int k;
         k  = i % 3;
         rc = {$urandom, $urandom};
         rx = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         run(k, rc, rx, model_p(rc, rx, k), $urandom_range(0, 3), $sformatf("rand%0d_k%0d", i, k));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time bound.
   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
